uart_frame_ctrl: RTL and testbench



---
 rtl/uart_frame_ctrl_pkg.sv | 36 +++
 rtl/uart_frame_ctrl_if.sv | 36 +++
 rtl/uart_frame_ctrl_bps_gen.sv | 49 ++++
 rtl/uart_frame_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_frame_pkg
// Brief  : Parser state encoding, default frame/baud settings and helpers.
// Rev    : 1.0  initial release
// ============================================================================
package uart_frame_pkg;

   localparam int         DEF_CLK_HZ       = 12_000_000;
   localparam int         DEF_BAUD         = 9600;
   localparam logic [7:0] DEF_SOF          = 8'hA5;
   localparam int         DEF_MAX_LEN      = 16;
   localparam int         DEF_TIMEOUT_BITS = 40;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHECK   = 3'd3,
      ST_DRAIN   = 3'd4
   } state_e;

   function automatic int bps_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int bps_half(input int clk_hz, input int baud);
      return bps_div(clk_hz, baud) / 2;
   endfunction

   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : uart_frame_ctrl_if
// Brief  : Receiver beat handshake, byte strobe, payload stream and status.
// Rev    : 1.0  initial release
// ============================================================================
interface uart_frame_ctrl_if;

   logic       bps_en;
   logic       bps_clk;
   logic       rx_data_valid;
   logic [7:0] rx_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
   logic       err_len;
   logic       err_chk;
   logic       err_busy;
   logic       err_timeout;

   modport master (
      input  bps_en, rx_data_valid, rx_data, out_ready,
      output bps_clk, out_valid, out_data, out_last, busy,
             err_len, err_chk, err_busy, err_timeout
   );

   modport slave (
      output bps_en, rx_data_valid, rx_data, out_ready,
      input  bps_clk, out_valid, out_data, out_last, busy,
             err_len, err_chk, err_busy, err_timeout
   );

endinterface
`default_nettype wire

// File: rtl/uart_frame_ctrl_bps_gen.sv
`default_nettype none
// ============================================================================
// Module : uart_bps_gen
// Brief  : Mid-bit beat strobe, first pulse BPS_HALF clocks after enable.
// Rev    : 1.0  initial release
// ============================================================================
module uart_bps_gen
   import uart_frame_pkg::*;
#(
   parameter int CLK_HZ = DEF_CLK_HZ,
   parameter int BAUD   = DEF_BAUD
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic bps_en_i,
   output logic bps_clk_o
);

   localparam int BPS_DIV  = bps_div(CLK_HZ, BAUD);
   localparam int BPS_HALF = bps_half(CLK_HZ, BAUD);
   localparam int CNT_W    = $clog2(BPS_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bps_clk_q, bps_clk_d;

   // Gating the pulse with the enable drops a beat that would coincide with disable.
   always_comb begin
      cnt_d     = '0;
      bps_clk_d = 1'b0;
      if (bps_en_i) begin
         cnt_d     = (cnt_q == CNT_W'(BPS_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
         bps_clk_d = (cnt_q == CNT_W'(BPS_HALF - 1));
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q     <= '0;
         bps_clk_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bps_clk_q <= bps_clk_d;
      end
   end

   assign bps_clk_o = bps_clk_q;

endmodule
`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_frame_ctrl
// Brief  : SOF/LEN/PAYLOAD/CHK frame parser with payload buffer and drain.
//          Optional inter-byte timeout: define UART_FRAME_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module uart_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter int         CLK_HZ       = DEF_CLK_HZ,
   parameter int         BAUD         = DEF_BAUD,
   parameter logic [7:0] SOF          = DEF_SOF,
   parameter int         MAX_LEN      = DEF_MAX_LEN,
   parameter int         TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
   input  logic              clk_in,
   input  logic              rst_in,
   uart_frame_ctrl_if.master bus
);

   localparam int LEN_W = len_width(MAX_LEN);
   localparam int PTR_W = $clog2(MAX_LEN);

   if (MAX_LEN < 2 || MAX_LEN > 255 || TIMEOUT_BITS < 1) begin : g_param_err
      $error("uart_frame_ctrl: unsupported MAX_LEN or TIMEOUT_BITS");
   end

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]       sum_q, sum_d;
   logic [7:0]       buf_q [MAX_LEN];
   logic             buf_we;
   logic             err_len_q, err_len_d;
   logic             err_chk_q, err_chk_d;
   logic             err_busy_q, err_busy_d;
   logic             len_ok, wr_last, rd_last, draining;

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int TO_LIMIT = TIMEOUT_BITS * bps_div(CLK_HZ, BAUD);
   localparam int TO_W     = $clog2(TO_LIMIT);

   logic [TO_W-1:0] idle_q, idle_d;
   logic            err_to_q, err_to_d;
`endif

   uart_bps_gen #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_bps_gen (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .bps_en_i  (bus.bps_en),
      .bps_clk_o (bus.bps_clk)
   );

   assign len_ok   = (bus.rx_data != 8'd0) && (bus.rx_data <= 8'(MAX_LEN));
   assign wr_last  = (LEN_W'(wr_ptr_q) == len_q - LEN_W'(1));
   assign rd_last  = (LEN_W'(rd_ptr_q) == len_q - LEN_W'(1));
   assign draining = (state_q == ST_DRAIN);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      sum_d      = sum_q;
      buf_we     = 1'b0;
      err_len_d  = 1'b0;
      err_chk_d  = 1'b0;
      err_busy_d = 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      idle_d     = '0;
      err_to_d   = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (bus.rx_data_valid && bus.rx_data == SOF) state_d = ST_LEN;
         end
         ST_LEN: begin
            if (bus.rx_data_valid) begin
               if (len_ok) begin
                  len_d    = LEN_W'(bus.rx_data);
                  sum_d    = bus.rx_data;
                  wr_ptr_d = '0;
                  state_d  = ST_PAYLOAD;
               end else begin
                  err_len_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_PAYLOAD: begin
            if (bus.rx_data_valid) begin
               buf_we   = 1'b1;
               sum_d    = sum_q + bus.rx_data;
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
               if (wr_last) state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (bus.rx_data_valid) begin
               if (bus.rx_data == sum_q) begin
                  rd_ptr_d = '0;
                  state_d  = ST_DRAIN;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            // Bytes arriving while the buffer drains are discarded, never parsed.
            if (bus.rx_data_valid) err_busy_d = 1'b1;
            if (bus.out_ready) begin
               if (rd_last) state_d  = ST_IDLE;
               else         rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef UART_FRAME_TIMEOUT_EN
      // A strobe on the expiry cycle takes priority, so only silence can expire.
      if ((state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHECK)
          && !bus.rx_data_valid) begin
         if (idle_q == TO_W'(TO_LIMIT - 1)) begin
            err_to_d = 1'b1;
            state_d  = ST_IDLE;
         end else begin
            idle_d = idle_q + TO_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sum_q      <= '0;
         err_len_q  <= 1'b0;
         err_chk_q  <= 1'b0;
         err_busy_q <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
         idle_q     <= '0;
         err_to_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         sum_q      <= sum_d;
         err_len_q  <= err_len_d;
         err_chk_q  <= err_chk_d;
         err_busy_q <= err_busy_d;
`ifdef UART_FRAME_TIMEOUT_EN
         idle_q     <= idle_d;
         err_to_q   <= err_to_d;
`endif
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
      end else if (buf_we) begin
         buf_q[wr_ptr_q] <= bus.rx_data;
      end
   end

   assign bus.out_valid = draining;
   assign bus.out_data  = draining ? buf_q[rd_ptr_q] : 8'd0;
   assign bus.out_last  = draining && rd_last;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.err_len   = err_len_q;
   assign bus.err_chk   = err_chk_q;
   assign bus.err_busy  = err_busy_q;
`ifdef UART_FRAME_TIMEOUT_EN
   assign bus.err_timeout = err_to_q;
`else
   assign bus.err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_frame_ctrl
// Brief  : Randomized frame stimulus against a frame-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_frame_ctrl;

   localparam int         CLK_HZ   = 12_000_000;
   localparam int         BAUD     = 9600;
   localparam int         BPS_DIV  = CLK_HZ / BAUD;
   localparam int         BPS_HALF = BPS_DIV / 2;
   localparam int         MAX_LEN  = 16;
   localparam int         TO_BITS  = 4;
   localparam int         TO_LIMIT = TO_BITS * BPS_DIV;
   localparam logic [7:0] SOF      = 8'hA5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_frame_ctrl_if ifc ();

   uart_frame_ctrl #(
      .CLK_HZ       (CLK_HZ),
      .BAUD         (BAUD),
      .SOF          (SOF),
      .MAX_LEN      (MAX_LEN),
      .TIMEOUT_BITS (TO_BITS)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (ifc)
   );

   int n_checks = 0;
   int n_errors = 0;
   int rdy_mode = 1;
   int exp_len = 0, exp_chk = 0, exp_busy = 0, exp_to = 0;
   int cnt_len = 0, cnt_chk = 0, cnt_busy = 0, cnt_to = 0;
   int hold_viol = 0, hold_cycles = 0, width_viol = 0;
   int got_idx = 0;
   logic [8:0] got_q [$];
   logic [8:0] exp_q [$];
   logic [7:0] pay [$];
   logic       prev_stall = 1'b0;
   logic [8:0] prev_out = '0;
   logic [3:0] prev_err = '0;
   logic [3:0] errs;

   assign errs = {ifc.err_len, ifc.err_chk, ifc.err_busy, ifc.err_timeout};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Downstream readiness: 0 = stall, 1 = always ready, 2 = random.
   initial begin
      ifc.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       ifc.out_ready = 1'b0;
            1:       ifc.out_ready = 1'b1;
            default: ifc.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (ifc.out_valid && ifc.out_ready) got_q.push_back({ifc.out_last, ifc.out_data});
         if (prev_stall && ({ifc.out_last, ifc.out_data} != prev_out)) hold_viol <= hold_viol + 1;
         if (ifc.out_valid && !ifc.out_ready) hold_cycles <= hold_cycles + 1;
         if ((errs & prev_err) != 4'd0) width_viol <= width_viol + 1;
         prev_stall <= ifc.out_valid && !ifc.out_ready;
         prev_out   <= {ifc.out_last, ifc.out_data};
         prev_err   <= errs;
         cnt_len    <= cnt_len  + int'(ifc.err_len);
         cnt_chk    <= cnt_chk  + int'(ifc.err_chk);
         cnt_busy   <= cnt_busy + int'(ifc.err_busy);
         cnt_to     <= cnt_to   + int'(ifc.err_timeout);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      ifc.rx_data_valid = 1'b1;
      ifc.rx_data       = b;
      @(negedge clk);
      ifc.rx_data_valid = 1'b0;
   endtask

   function automatic logic [7:0] csum();
      int s = pay.size();
      foreach (pay[i]) s += int'(pay[i]);
      return 8'(s);
   endfunction

   task automatic rand_payload(input int len);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic push_exp();
      foreach (pay[i]) exp_q.push_back({(i == pay.size() - 1), pay[i]});
   endtask

   // Sends SOF, LEN, payload and (checksum ^ chk_xor); stops right after the final strobe.
   task automatic send_frame(input logic [7:0] chk_xor, input int maxgap);
      send_byte(SOF);
      idle($urandom_range(0, maxgap));
      send_byte(8'(pay.size()));
      idle($urandom_range(0, maxgap));
      foreach (pay[i]) begin
         send_byte(pay[i]);
         idle($urandom_range(0, maxgap));
      end
      send_byte(csum() ^ chk_xor);
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (!ifc.busy) break;
         @(negedge clk);
      end
      check_val("drain_done_busy", 32'(ifc.busy), 32'd0);
   endtask

   task automatic compare_payload(input string tag);
      int n_got;
      #1;
      n_got = got_q.size() - got_idx;
      check_val({tag, "_count"}, 32'(n_got), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n_got; i++)
         check_val($sformatf("%s_byte%0d", tag, i), 32'(got_q[got_idx + i]), 32'(exp_q[i]));
      got_idx = got_q.size();
      exp_q.delete();
   endtask

   task automatic check_counts(input string tag);
      #1;
      check_val({tag, "_err_len"},     32'(cnt_len),  32'(exp_len));
      check_val({tag, "_err_chk"},     32'(cnt_chk),  32'(exp_chk));
      check_val({tag, "_err_busy"},    32'(cnt_busy), 32'(exp_busy));
      check_val({tag, "_err_timeout"}, 32'(cnt_to),   32'(exp_to));
   endtask

   task automatic send_valid(input int maxgap);
      push_exp();
      send_frame(8'h00, maxgap);
      check_val("valid_after_chk", 32'(ifc.out_valid), 32'd1);
      wait_idle(2000);
      compare_payload("frame");
   endtask

   task automatic bps_run(input int len);
      int  pulses = 0;
      logic exp;
      for (int n = 1; n <= len + 3; n++) begin
         ifc.bps_en = (n <= len);
         @(negedge clk);
         exp = (n <= len) && (n >= BPS_HALF) && (((n - BPS_HALF) % BPS_DIV) == 0);
         if (exp || ifc.bps_clk)
            check_val($sformatf("bps_clk_len%0d_clk%0d", len, n), 32'(ifc.bps_clk), 32'(exp));
         pulses += int'(ifc.bps_clk);
      end
      check_val($sformatf("bps_count_len%0d", len), 32'(pulses),
                32'((len >= BPS_HALF) ? ((len - BPS_HALF) / BPS_DIV + 1) : 0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int kind;
      logic [7:0] b;
      ifc.bps_en        = 1'b0;
      ifc.rx_data_valid = 1'b0;
      ifc.rx_data       = 8'd0;
      idle(4);
      check_val("reset_outputs",
                32'({ifc.bps_clk, ifc.out_valid, ifc.out_data, ifc.out_last, ifc.busy, errs}), 32'd0);
      rst = 1'b0;
      idle(3);

      // Known frame, then a second frame starting on the first IDLE cycle.
      pay = '{8'h11, 8'h22, 8'h33};
      push_exp();
      send_frame(8'h00, 0);
      check_val("t1_valid_latency", 32'(ifc.out_valid), 32'd1);
      check_val("t1_first_data", 32'(ifc.out_data), 32'h11);
      idle(3);
      check_val("t1_idle_after_drain", 32'(ifc.busy), 32'd0);
      pay = '{SOF, 8'h00, 8'h7F};
      push_exp();
      send_frame(8'h00, 0);
      wait_idle(100);
      compare_payload("t1");
      check_counts("t1");

      // Checksum off by one.
      pay = '{8'h11, 8'h22, 8'h33};
      send_frame(8'h01, 0);
      exp_chk++;
      check_val("t2_err_chk", 32'(ifc.err_chk), 32'd1);
      check_val("t2_no_valid", 32'(ifc.out_valid), 32'd0);
      check_val("t2_busy", 32'(ifc.busy), 32'd0);
      idle(4);
      compare_payload("t2");

      // Illegal lengths, then a legal frame.
      send_byte(SOF);
      send_byte(8'h00);
      check_val("t3_err_len_zero", 32'(ifc.err_len), 32'd1);
      send_byte(SOF);
      send_byte(8'(MAX_LEN + 1));
      check_val("t3_err_len_big", 32'(ifc.err_len), 32'd1);
      exp_len += 2;
      rand_payload(5);
      send_valid(0);
      check_counts("t3");

      // Stalled drain with bytes arriving meanwhile.
      rdy_mode = 0;
      idle(2);
      pay = '{8'h11, 8'h22, 8'h33};
      push_exp();
      send_frame(8'h00, 0);
      for (int k = 0; k < 50; k++) begin
         if (k % 10 == 3) send_byte(8'($urandom_range(0, 255)));
         else             idle(1);
      end
      exp_busy += 5;
      check_val("t4_hold_valid", 32'(ifc.out_valid), 32'd1);
      check_val("t4_hold_data", 32'(ifc.out_data), 32'h11);
      rdy_mode = 1;
      wait_idle(100);
      compare_payload("t4");
      check_counts("t4");

      // Randomized frame mix with random backpressure.
      rdy_mode = 2;
      for (int f = 0; f < 24; f++) begin
         kind = int'($urandom_range(0, 3));
         rand_payload(int'($urandom_range(1, MAX_LEN)));
         case (kind)
            0: send_valid(2);
            1: begin
               send_frame(8'($urandom_range(1, 255)), 2);
               exp_chk++;
               check_val("rnd_err_chk", 32'(ifc.err_chk), 32'd1);
               check_val("rnd_chk_no_valid", 32'(ifc.out_valid), 32'd0);
            end
            2: begin
               send_byte(SOF);
               if ($urandom_range(0, 1) == 0) send_byte(8'd0);
               else send_byte(8'($urandom_range(MAX_LEN + 1, 255)));
               exp_len++;
               check_val("rnd_err_len", 32'(ifc.err_len), 32'd1);
            end
            default: begin
               for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                  do b = 8'($urandom_range(0, 255)); while (b == SOF);
                  send_byte(b);
               end
               send_valid(1);
            end
         endcase
      end
      rdy_mode = 1;
      idle(4);
      compare_payload("rnd");
      check_counts("rnd");

      // Beat generator.
      bps_run(12);
      bps_run(BPS_HALF - 1);
      bps_run(BPS_HALF);
      bps_run(int'($urandom_range(BPS_HALF + 1, 3 * BPS_DIV)));
      bps_run(10000);

`ifdef UART_FRAME_TIMEOUT_EN
      begin
         int early = 0;
         send_byte(SOF);
         send_byte(8'h03);
         send_byte(8'h11);
         for (int j = 1; j <= TO_LIMIT; j++) begin
            @(negedge clk);
            if (j < TO_LIMIT) early += int'(ifc.err_timeout);
            else check_val("to_fire", 32'(ifc.err_timeout), 32'd1);
         end
         exp_to++;
         check_val("to_early", 32'(early), 32'd0);
         check_val("to_busy_after", 32'(ifc.busy), 32'd0);
         pay = '{8'h11, 8'h22, 8'h33};
         push_exp();
         send_byte(SOF);
         send_byte(8'h03);
         send_byte(8'h11);
         idle(TO_LIMIT - 1);
         send_byte(8'h22);
         send_byte(8'h33);
         send_byte(8'h69);
         check_val("to_expiry_byte_valid", 32'(ifc.out_valid), 32'd1);
         wait_idle(100);
         compare_payload("to");
         check_counts("to");
      end
`else
      pay = '{8'h11, 8'h22, 8'h33};
      push_exp();
      send_byte(SOF);
      send_byte(8'h03);
      send_byte(8'h11);
      idle(TO_LIMIT + 20);
      check_val("no_to_busy", 32'(ifc.busy), 32'd1);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h69);
      wait_idle(100);
      compare_payload("no_to");
      check_counts("no_to");
`endif

      #1;
      check_val("hold_stable_viol", 32'(hold_viol), 32'd0);
      check_val("hold_exercised", 32'(hold_cycles != 0), 32'd1);
      check_val("pulse_width_viol", 32'(width_viol), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
